// File: rtl/axi_slave.sv
// rtl/axi_slave.sv - AXI4 INCR-burst slave memory model with beat/burst counters
//
// Purpose: word-array memory behind an AXI4 slave port. One write burst and one
// read burst may be in flight at the same time, on independent channels.
//
// Ports:
//   axi_aclk, axi_resetn        clock, synchronous active-low reset
//   axi_aw* / axi_w* / axi_b*   write address, data and response channels
//   axi_ar* / axi_r*            read address and data channels
//   wr_beats                    accepted write beats (saturating)
//   wr_bursts, rd_bursts        completed write / read bursts (wrapping)
//   rx_enough                   sticky flag, wr_beats reached ENOUGH_BEATS
module axi_slave #(
    parameter int ASIZE        = 29,
    parameter int DSIZE        = 256,
    parameter int LSIZE        = 9,
    parameter int IDSIZE       = 4,
    parameter int ID           = 0,
    parameter int ADDR_STEP    = 64,
    parameter int DEPTH        = 1024,
    parameter int ENOUGH_BEATS = 256
) (
    input  logic               axi_aclk,
    input  logic               axi_resetn,
    input  logic [IDSIZE-1:0]  axi_awid,
    input  logic [ASIZE-1:0]   axi_awaddr,
    input  logic [LSIZE-1:0]   axi_awlen,
    input  logic [2:0]         axi_awsize,
    input  logic [1:0]         axi_awburst,
    input  logic               axi_awlock,
    input  logic [3:0]         axi_awcache,
    input  logic [2:0]         axi_awprot,
    input  logic [3:0]         axi_awqos,
    input  logic               axi_awvalid,
    output logic               axi_awready,
    input  logic [DSIZE-1:0]   axi_wdata,
    input  logic [DSIZE/8-1:0] axi_wstrb,
    input  logic               axi_wlast,
    input  logic               axi_wvalid,
    output logic               axi_wready,
    output logic [IDSIZE-1:0]  axi_bid,
    output logic [1:0]         axi_bresp,
    output logic               axi_bvalid,
    input  logic               axi_bready,
    input  logic [IDSIZE-1:0]  axi_arid,
    input  logic [ASIZE-1:0]   axi_araddr,
    input  logic [LSIZE-1:0]   axi_arlen,
    input  logic [2:0]         axi_arsize,
    input  logic [1:0]         axi_arburst,
    input  logic               axi_arlock,
    input  logic [3:0]         axi_arcache,
    input  logic [2:0]         axi_arprot,
    input  logic [3:0]         axi_arqos,
    input  logic               axi_arvalid,
    output logic               axi_arready,
    output logic [IDSIZE-1:0]  axi_rid,
    output logic [DSIZE-1:0]   axi_rdata,
    output logic [1:0]         axi_rresp,
    output logic               axi_rlast,
    output logic               axi_rvalid,
    input  logic               axi_rready,
    output logic [31:0]        wr_beats,
    output logic [15:0]        wr_bursts,
    output logic [15:0]        rd_bursts,
    output logic               rx_enough
);

    localparam int IW = $clog2(DEPTH);
    localparam int NB = DSIZE / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [DSIZE-1:0]  r_mem [DEPTH];
    logic              r_live;
    wstate_t           r_wstate, w_wstate_next;
    rstate_t           r_rstate, w_rstate_next;
    logic [IW-1:0]     r_wr_index, r_rd_index;
    logic [LSIZE-1:0]  r_wr_remaining, r_rd_remaining;
    logic [IDSIZE-1:0] r_bid, r_rid;
    logic [1:0]        r_bresp;
    logic [31:0]       r_wr_beats;
    logic [15:0]       r_wr_bursts, r_rd_bursts;
    logic              r_rx_enough;

    logic              w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
    logic              w_aw_fire, w_wr_fire, w_b_fire, w_ar_fire, w_r_fire;
    logic              w_wr_last, w_rlast;
    logic [IW-1:0]     w_aw_index, w_ar_index;

    // Sideband fields that do not affect this model.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, axi_awsize, axi_awburst, axi_awlock, axi_awcache,
                           axi_awprot, axi_awqos, axi_arsize, axi_arburst, axi_arlock,
                           axi_arcache, axi_arprot, axi_arqos};

    // Truncation of the word address to IW bits gives the mod-DEPTH wrap.
    assign w_aw_index = IW'(axi_awaddr / ASIZE'(ADDR_STEP));
    assign w_ar_index = IW'(axi_araddr / ASIZE'(ADDR_STEP));

    // Handshakes are gated by reset so a burst cut by reset leaves no trace.
    assign w_aw_fire = axi_resetn & axi_awvalid & w_awready;
    assign w_wr_fire = axi_resetn & axi_wvalid  & w_wready;
    assign w_b_fire  = axi_resetn & axi_bready  & w_bvalid;
    assign w_ar_fire = axi_resetn & axi_arvalid & w_arready;
    assign w_r_fire  = axi_resetn & axi_rready  & w_rvalid;

    // Burst ends on whichever comes first: counted length or wlast.
    assign w_wr_last = (r_wr_remaining == '0) | axi_wlast;
    assign w_rlast   = (r_rstate == R_DATA) & (r_rd_remaining == '0);

    // r_live holds the address channels off during the first reset-release cycle.
    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            r_live   <= 1'b0;
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_live   <= 1'b1;
            r_wstate <= w_wstate_next;
            r_rstate <= w_rstate_next;
        end
    end

    always_comb begin
        w_wstate_next = r_wstate;
        w_awready     = 1'b0;
        w_wready      = 1'b0;
        w_bvalid      = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = r_live;
                if (axi_awvalid && r_live) w_wstate_next = W_DATA;
            end
            W_DATA: begin
                w_wready = 1'b1;
                if (axi_wvalid && w_wr_last) w_wstate_next = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (axi_bready) w_wstate_next = W_IDLE;
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_next = r_rstate;
        w_arready     = 1'b0;
        w_rvalid      = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = r_live;
                if (axi_arvalid && r_live) w_rstate_next = R_DATA;
            end
            R_DATA: begin
                w_rvalid = 1'b1;
                if (axi_rready && w_rlast) w_rstate_next = R_IDLE;
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            r_wr_index     <= '0;
            r_wr_remaining <= '0;
            r_bid          <= IDSIZE'(ID);
            r_bresp        <= 2'b00;
            r_wr_beats     <= '0;
            r_wr_bursts    <= '0;
            r_rx_enough    <= 1'b0;
        end else begin
            if (w_aw_fire) begin
                r_bid          <= axi_awid;
                r_wr_index     <= w_aw_index;
                r_wr_remaining <= axi_awlen;
            end
            if (w_wr_fire) begin
                r_wr_index     <= r_wr_index + IW'(1);
                r_wr_remaining <= r_wr_remaining - LSIZE'(1);
                if (r_wr_beats != '1) r_wr_beats <= r_wr_beats + 32'd1;
                if (w_wr_last)
                    r_bresp <= ((r_wr_remaining == '0) != axi_wlast) ? 2'b10 : 2'b00;
            end
            if (w_b_fire) r_wr_bursts <= r_wr_bursts + 16'd1;
            r_rx_enough <= r_rx_enough | (r_wr_beats >= 32'(ENOUGH_BEATS));
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            r_rd_index     <= '0;
            r_rd_remaining <= '0;
            r_rid          <= IDSIZE'(ID);
            r_rd_bursts    <= '0;
        end else begin
            if (w_ar_fire) begin
                r_rid          <= axi_arid;
                r_rd_index     <= w_ar_index;
                r_rd_remaining <= axi_arlen;
            end
            if (w_r_fire) begin
                r_rd_index     <= r_rd_index + IW'(1);
                r_rd_remaining <= r_rd_remaining - LSIZE'(1);
                if (w_rlast) r_rd_bursts <= r_rd_bursts + 16'd1;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge axi_aclk) begin
        for (int b = 0; b < NB; b++) begin
            if (w_wr_fire && axi_wstrb[b])
                r_mem[r_wr_index][b*8 +: 8] <= axi_wdata[b*8 +: 8];
        end
    end

    assign axi_awready = w_awready;
    assign axi_wready  = w_wready;
    assign axi_bvalid  = w_bvalid;
    assign axi_bid     = r_bid;
    assign axi_bresp   = r_bresp;
    assign axi_arready = w_arready;
    assign axi_rvalid  = w_rvalid;
    assign axi_rid     = r_rid;
    assign axi_rresp   = 2'b00;
    assign axi_rlast   = w_rlast;
    // Combinational read: a same-cycle write to this word shows up next cycle.
    assign axi_rdata   = r_mem[r_rd_index];
    assign wr_beats    = r_wr_beats;
    assign wr_bursts   = r_wr_bursts;
    assign rd_bursts   = r_rd_bursts;
    assign rx_enough   = r_rx_enough;

endmodule

// File: tb/tb_axi_slave.sv
// tb/tb_axi_slave.sv - scoreboard testbench for axi_slave
module tb_axi_slave;

    localparam int ASIZE = 29, DSIZE = 256, LSIZE = 9, IDSIZE = 4;
    localparam int ADDR_STEP = 64, DEPTH = 1024, ENOUGH = 256;

    logic               clk = 1'b0;
    logic               resetn;
    logic [IDSIZE-1:0]  awid, arid;
    logic [ASIZE-1:0]   awaddr, araddr;
    logic [LSIZE-1:0]   awlen, arlen;
    logic               awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [DSIZE-1:0]   wdata;
    logic [DSIZE/8-1:0] wstrb;
    logic               awready, wready, bvalid, arready, rvalid, rlast, rx_enough;
    logic [IDSIZE-1:0]  bid, rid;
    logic [1:0]         bresp, rresp;
    logic [DSIZE-1:0]   rdata;
    logic [31:0]        wr_beats;
    logic [15:0]        wr_bursts, rd_bursts;

    axi_slave dut (
        .axi_aclk(clk), .axi_resetn(resetn),
        .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(3'd5),
        .axi_awburst(2'b01), .axi_awlock(1'b0), .axi_awcache(4'd0), .axi_awprot(3'd0),
        .axi_awqos(4'd0), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid),
        .axi_wready(wready), .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid),
        .axi_bready(bready), .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen),
        .axi_arsize(3'd5), .axi_arburst(2'b01), .axi_arlock(1'b0), .axi_arcache(4'd0),
        .axi_arprot(3'd0), .axi_arqos(4'd0), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast),
        .axi_rvalid(rvalid), .axi_rready(rready), .wr_beats(wr_beats),
        .wr_bursts(wr_bursts), .rd_bursts(rd_bursts), .rx_enough(rx_enough)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DSIZE-1:0]  data;
        logic              last;
        logic [IDSIZE-1:0] id;
    } rexp_t;

    rexp_t            rq[$];
    logic [5:0]       bq[$];
    logic [DSIZE-1:0] model [DEPTH];
    int               n_checks = 0;
    int               n_errors = 0;
    bit               mon_en = 0;
    int               tb_beats = 0, tb_wb = 0, tb_rb = 0;
    bit               tb_en = 0;

    task automatic check(input string tag, input logic [DSIZE-1:0] got, input logic [DSIZE-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Monitor samples midway in the low phase; drivers change inputs on the
    // falling edge (channels) or just after the rising edge (rready).
    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            check("wr_beats", wr_beats, tb_beats);
            check("rx_enough", rx_enough, tb_en);
            check("wr_bursts", wr_bursts, tb_wb);
            check("rd_bursts", rd_bursts, tb_rb);
            if (bvalid) begin
                if (bq.size() == 0) check("b_unexpected", bvalid, 1'b0);
                else begin
                    check("bresp", bresp, bq[0][5:4]);
                    check("bid", bid, bq[0][3:0]);
                    if (bready) begin void'(bq.pop_front()); tb_wb++; end
                end
            end
            if (rvalid) begin
                if (rq.size() == 0) check("r_unexpected", rvalid, 1'b0);
                else begin
                    check("rdata", rdata, rq[0].data);
                    check("rlast", rlast, rq[0].last);
                    check("rid", rid, rq[0].id);
                    check("rresp", rresp, 2'b00);
                    if (rready) begin
                        if (rq[0].last) tb_rb++;
                        void'(rq.pop_front());
                    end
                end
            end
        end
        tb_en = tb_en | (tb_beats >= ENOUGH);
        if (resetn && wvalid && wready) tb_beats++;
    end

    task automatic do_write(input int idx, input int len, input int wlast_at,
                            input int zero_at, input int base, input logic [IDSIZE-1:0] id);
        int nbeats;
        int cnt;
        nbeats = ((wlast_at < len) ? wlast_at : len) + 1;
        bq.push_back({(wlast_at != len) ? 2'b10 : 2'b00, id});
        @(negedge clk);
        awvalid = 1'b1; awaddr = ASIZE'(idx * ADDR_STEP); awlen = LSIZE'(len); awid = id;
        cnt = 0;
        while (!awready && cnt < 50) begin @(negedge clk); cnt++; end
        if (!awready) check("aw_timeout", awready, 1'b1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            wvalid = 1'b1;
            wdata  = DSIZE'(base + b);
            wstrb  = (b == zero_at) ? '0 : '1;
            wlast  = (b == wlast_at);
            cnt = 0;
            while (!wready && cnt < 50) begin @(negedge clk); cnt++; end
            if (!wready) check("w_timeout", wready, 1'b1);
            if (b != zero_at) model[(idx + b) % DEPTH] = DSIZE'(base + b);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        #1 check("b_next_cycle", bvalid, 1'b1);
        cnt = 0;
        while (bq.size() != 0 && cnt < 50) begin @(negedge clk); cnt++; end
        check("b_drain", bq.size(), 0);
    endtask

    task automatic do_read(input int idx, input int len, input logic [IDSIZE-1:0] id, input bit toggle);
        int cnt;
        for (int b = 0; b <= len; b++) begin
            rexp_t e;
            e.data = model[(idx + b) % DEPTH];
            e.last = (b == len);
            e.id   = id;
            rq.push_back(e);
        end
        @(negedge clk);
        arvalid = 1'b1; araddr = ASIZE'(idx * ADDR_STEP); arlen = LSIZE'(len); arid = id;
        cnt = 0;
        while (!arready && cnt < 50) begin @(negedge clk); cnt++; end
        if (!arready) check("ar_timeout", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        cnt = 0;
        while (rq.size() != 0 && cnt < 2000) begin
            @(posedge clk);
            #1;
            if (toggle) rready = ~rready;
            cnt++;
        end
        rready = 1'b1;
        check("r_drain", rq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1; awid = '0; arid = '0; awaddr = '0; araddr = '0;
        awlen = '0; arlen = '0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_awready", awready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_bid", bid, 4'd0);
        check("rst_rid", rid, 4'd0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_rx_enough", rx_enough, 1'b0);
        check("rst_wr_beats", wr_beats, 32'd0);
        resetn = 1'b1;
        #1 check("rel_awready_early", awready, 1'b0);
        @(posedge clk);
        #1;
        check("rel_awready", awready, 1'b1);
        check("rel_arready", arready, 1'b1);
        mon_en = 1'b1;

        do_write(0, 3, 3, -1, 0, 4'h5);
        check("t2_wr_beats", wr_beats, 32'd4);
        check("t2_wr_bursts", wr_bursts, 16'd1);

        do_read(0, 3, 4'hA, 1'b0);
        check("t3_rd_bursts", rd_bursts, 16'd1);
        do_read(0, 3, 4'h3, 1'b1);

        do_write(8, 7, 7, -1, 32'hA0, 4'h1);
        check("t5_enough_before", rx_enough, 1'b0);
        do_write(8, 255, 255, 5, 32'h1000, 4'h7);
        check("t5_enough_after", rx_enough, 1'b1);
        do_read(8, 15, 4'h2, 1'b0);

        do_write(600, 3, 1, -1, 32'h300, 4'h9);
        do_write(700, 0, 0, -1, 32'h400, 4'h4);
        do_read(600, 1, 4'h6, 1'b0);
        do_read(700, 0, 4'h6, 1'b0);

        do_write(DEPTH - 2, 3, 3, -1, 32'h500, 4'hC);
        do_read(DEPTH - 2, 3, 4'hD, 1'b1);
        do_read(0, 1, 4'hE, 1'b0);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
